fpu_decode_queue: RTL and testbench
===================================

Name: fpu_decode_queue

Overview:
- Buffered, handshaked front end for the 8087 FPU core.
- Accepts 16-bit ESC instruction words (opcode byte in [15:8], ModR/M in [7:0]) from the CPU bus interface and decodes each word on entry.
- Stores the decoded bundle in a DEPTH-entry circular queue and presents it to the FPU microsequencer through a valid/ready port, so the CPU can issue ahead of FPU execution.
- Illegal encodings are queued and flagged, not dropped.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2 to 16.
- TAG_W, 4, width of the CPU-supplied tag carried with each instruction.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous queue clear (FWAIT abort / CPU reset of the FPU).
- in_valid  in  1  instruction word offered.
- in_ready  out  1  queue can accept.
- in_instr  in  16  ESC opcode byte and ModR/M byte.
- in_tag  in  TAG_W  opaque tag returned with the entry.
- out_valid  out  1  head entry valid.
- out_ready  in  1  sequencer consumes the head.
- out_opcode  out  8  internal opcode.
- out_stack_index  out  3  ST(i) index.
- out_has_memory_op, out_has_pop, out_has_push  out  1 each  decode flags.
- out_operand_size  out  2  memory operand size code.
- out_is_integer, out_is_bcd, out_uses_st0_sti, out_uses_sti_st0  out  1 each  decode flags.
- out_illegal  out  1  decoder reported the word invalid.
- out_tag  out  TAG_W  tag of the head entry.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - write pointer, read pointer and count = 0.
  - out_valid = 0; in_ready = 1 after reset deasserts.
  - All out_* data = 0.
  - Entry storage need not be cleared.
- Decode:
  - Combinational on in_instr at enqueue, with decode enabled.
  - The full bundle plus out_illegal = !decoder_valid and in_tag is written into entry[wptr].
- Push: in_valid & in_ready at a rising edge. wptr increments modulo DEPTH.
- Pop: out_valid & out_ready at a rising edge. rptr increments modulo DEPTH.
- Outputs are driven from entry[rptr]. They are valid only while out_valid = 1, and are held stable while out_valid & !out_ready.
- Latency: a word pushed into an empty queue at edge N gives out_valid = 1 in the cycle after N. There is no combinational in-to-out path.
- Flags: in_ready = (count != DEPTH) & !flush; out_valid = (count != 0).
- Simultaneous push and pop, queue neither empty nor full: count unchanged, both pointers advance.
- Full: in_ready = 0. A pop in the same cycle does not allow a push; in_ready rises the cycle after.
- Empty: out_valid = 0 and out_ready is ignored.
- Flush: has priority over push and pop in the same cycle. The next cycle has count = 0, pointers = 0, out_valid = 0. No word is accepted during a flush cycle.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full versus empty is resolved by count.
- in_valid with in_ready = 0: the word is not captured. The source must hold it.

Optional Feature:
- Macro: FPU_DECODE_QUEUE_STATS_EN.
- With the macro defined, two extra outputs are added:
  - stat_accepted (16 bits): increments on every push.
  - stat_illegal (16 bits): increments on every push whose word decodes illegal.
  - Both counters saturate at 16'hFFFF.
  - Both are cleared by reset only; flush does not clear them.
- Without the macro, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Package fpu_decode_pkg holds:
  - the packed decoded-bundle typedef (opcode, stack index, flags, size, illegal);
  - its width constant;
  - the operand-size code constants.
- Sub-module: one instance of the existing FPU_Instruction_Decoder on the enqueue side.
- Queue storage and pointer logic stay inline.

Test Plan:
- Reset, push D9E8 with tag 1 → out_valid = 1 in the following cycle; out_has_memory_op = 0, out_illegal = 0, out_tag = 1; out_opcode equals a standalone decoder fed D9E8.
- Push D9E8, D9EB, D9EE, DB38 (tags 0 to 3) with out_ready = 0 → count = 4, in_ready = 0. Then out_ready = 1 → the four pop in order; DB38 shows out_has_memory_op = 1.
- Full queue, push and pop in the same cycle → push rejected, count = 3, in_ready = 1 in the next cycle. Then run 10 continuous push/pop cycles → order preserved across pointer wrap.
- Push a word the decoder marks invalid → entry is delivered with out_illegal = 1. With FPU_DECODE_QUEUE_STATS_EN, stat_illegal = 1 and stat_accepted = 1.
- Queue holding 3 entries, flush asserted together with in_valid → next cycle count = 0, out_valid = 0, and the new word is not queued.
- Assert reset asynchronously between edges with 2 entries queued → out_valid and count drop immediately without waiting for a clock edge. After release, in_ready = 1.

Source files
------------

// File: rtl/fpu_decode_pkg.sv
// Shared types for the 8087 ESC-instruction decode queue: decoded bundle layout
// and the memory operand size codes produced by the decoder.
package fpu_decode_pkg;

    localparam logic [4:0] ESC_PREFIX = 5'b11011;

    localparam logic [1:0] SIZE_16 = 2'd0;
    localparam logic [1:0] SIZE_32 = 2'd1;
    localparam logic [1:0] SIZE_64 = 2'd2;
    localparam logic [1:0] SIZE_80 = 2'd3;

    typedef struct packed {
        logic [7:0] opcode;
        logic [2:0] stack_index;
        logic       has_memory_op;
        logic       has_pop;
        logic       has_push;
        logic [1:0] operand_size;
        logic       is_integer;
        logic       is_bcd;
        logic       uses_st0_sti;
        logic       uses_sti_st0;
        logic       illegal;
    } decoded_t;

    localparam int DECODED_W = $bits(decoded_t);

endpackage

// File: rtl/fpu_decode_queue_decoder.sv
// FPU_Instruction_Decoder: combinational 8087 ESC decode of opcode byte + ModR/M.
// Fields of an encoding reported invalid are informational only.
module FPU_Instruction_Decoder
    import fpu_decode_pkg::*;
(
    input  logic        enable,
    input  logic [15:0] instruction,
    output logic [7:0]  opcode,
    output logic [2:0]  stack_index,
    output logic        has_memory_op,
    output logic        has_pop,
    output logic        has_push,
    output logic [1:0]  operand_size,
    output logic        is_integer,
    output logic        is_bcd,
    output logic        uses_st0_sti,
    output logic        uses_sti_st0,
    output logic        decode_valid
);
    logic [2:0] esc;
    logic [2:0] reg_field;
    logic [2:0] rm;
    logic       is_reg;

    assign esc       = instruction[10:8];
    assign reg_field = instruction[5:3];
    assign rm        = instruction[2:0];
    assign is_reg    = (instruction[7:6] == 2'b11);

    // Internal opcode is {register form, ESC group, ModR/M reg, 0}.
    always_comb begin
        opcode        = '0;
        stack_index   = '0;
        has_memory_op = 1'b0;
        has_pop       = 1'b0;
        has_push      = 1'b0;
        operand_size  = SIZE_16;
        is_integer    = 1'b0;
        is_bcd        = 1'b0;
        uses_st0_sti  = 1'b0;
        uses_sti_st0  = 1'b0;
        decode_valid  = 1'b0;
        if (enable && instruction[15:11] == ESC_PREFIX) begin
            decode_valid = 1'b1;
            opcode       = {is_reg, esc, reg_field, 1'b0};
            if (is_reg) begin
                stack_index = rm;
                case (esc)
                    3'd0: uses_st0_sti = 1'b1;
                    3'd1: begin
                        has_push = (reg_field == 3'd0) || (reg_field == 3'd5);
                        if (reg_field == 3'd3 || (reg_field == 3'd5 && rm == 3'd7))
                            decode_valid = 1'b0;
                    end
                    3'd3: decode_valid = (reg_field == 3'd4);
                    3'd4: uses_sti_st0 = 1'b1;
                    3'd5: begin
                        has_pop      = (reg_field == 3'd3);
                        decode_valid = (reg_field == 3'd0) || (reg_field == 3'd2) || (reg_field == 3'd3);
                    end
                    3'd6: begin
                        uses_sti_st0 = 1'b1;
                        has_pop      = 1'b1;
                        decode_valid = (reg_field != 3'd2);
                    end
                    default: decode_valid = 1'b0;
                endcase
            end else begin
                has_memory_op = 1'b1;
                // Odd ESC groups use reg 0 as load and reg 3 as store-and-pop.
                if (esc[0]) begin
                    has_push = (reg_field == 3'd0);
                    has_pop  = (reg_field == 3'd3);
                end
                case (esc)
                    3'd0: operand_size = SIZE_32;
                    3'd1: begin
                        operand_size = (reg_field == 3'd0 || reg_field == 3'd2 || reg_field == 3'd3) ? SIZE_32 : SIZE_16;
                        decode_valid = (reg_field != 3'd1);
                    end
                    3'd2: begin
                        operand_size = SIZE_32;
                        is_integer   = 1'b1;
                    end
                    3'd3: begin
                        case (reg_field)
                            3'd0, 3'd2, 3'd3: begin
                                operand_size = SIZE_32;
                                is_integer   = 1'b1;
                            end
                            3'd5: begin
                                operand_size = SIZE_80;
                                has_push     = 1'b1;
                            end
                            3'd7: begin
                                operand_size = SIZE_80;
                                has_pop      = 1'b1;
                            end
                            default: decode_valid = 1'b0;
                        endcase
                    end
                    3'd4: operand_size = SIZE_64;
                    3'd5: begin
                        operand_size = (reg_field == 3'd0 || reg_field == 3'd2 || reg_field == 3'd3) ? SIZE_64 : SIZE_16;
                        decode_valid = (reg_field != 3'd1) && (reg_field != 3'd5);
                    end
                    3'd6: begin
                        operand_size = SIZE_16;
                        is_integer   = 1'b1;
                    end
                    default: begin
                        case (reg_field)
                            3'd0, 3'd2, 3'd3: is_integer = 1'b1;
                            3'd4: begin
                                operand_size = SIZE_80;
                                is_bcd       = 1'b1;
                                has_push     = 1'b1;
                            end
                            3'd5: begin
                                operand_size = SIZE_64;
                                is_integer   = 1'b1;
                                has_push     = 1'b1;
                            end
                            3'd6: begin
                                operand_size = SIZE_80;
                                is_bcd       = 1'b1;
                                has_pop      = 1'b1;
                            end
                            3'd7: begin
                                operand_size = SIZE_64;
                                is_integer   = 1'b1;
                                has_pop      = 1'b1;
                            end
                            default: decode_valid = 1'b0;
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/fpu_decode_queue.sv
// Handshaked queue of decoded 8087 ESC instructions between CPU and FPU sequencer.
// Define FPU_DECODE_QUEUE_STATS_EN to add saturating accepted/illegal counters.
module fpu_decode_queue
    import fpu_decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_instr,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_opcode,
    output logic [2:0]                 out_stack_index,
    output logic                       out_has_memory_op,
    output logic                       out_has_pop,
    output logic                       out_has_push,
    output logic [1:0]                 out_operand_size,
    output logic                       out_is_integer,
    output logic                       out_is_bcd,
    output logic                       out_uses_st0_sti,
    output logic                       out_uses_sti_st0,
    output logic                       out_illegal,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FPU_DECODE_QUEUE_STATS_EN
    ,
    output logic [15:0]                stat_accepted,
    output logic [15:0]                stat_illegal
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C = 1;
    localparam logic [PW-1:0] ONE_P = 1;

    logic [PW-1:0]        wptr, rptr;
    logic                 push, pop;
    logic                 dec_valid;
    decoded_t             dec, head;
    logic [DECODED_W-1:0] bundle_mem [DEPTH];
    logic [TAG_W-1:0]     tag_mem [DEPTH];

    FPU_Instruction_Decoder u_decoder (
        .enable        (1'b1),
        .instruction   (in_instr),
        .opcode        (dec.opcode),
        .stack_index   (dec.stack_index),
        .has_memory_op (dec.has_memory_op),
        .has_pop       (dec.has_pop),
        .has_push      (dec.has_push),
        .operand_size  (dec.operand_size),
        .is_integer    (dec.is_integer),
        .is_bcd        (dec.is_bcd),
        .uses_st0_sti  (dec.uses_st0_sti),
        .uses_sti_st0  (dec.uses_sti_st0),
        .decode_valid  (dec_valid)
    );
    assign dec.illegal = !dec_valid;

    assign in_ready  = (count != FULL_COUNT) && !flush;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + ONE_P;
            if (pop)  rptr <= rptr + ONE_P;
            case ({push, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            bundle_mem[wptr] <= dec;
            tag_mem[wptr]    <= in_tag;
        end
    end

    // Storage is never cleared, so the head is masked to zero while empty.
    assign head    = out_valid ? decoded_t'(bundle_mem[rptr]) : '0;
    assign out_tag = out_valid ? tag_mem[rptr] : '0;

    assign out_opcode        = head.opcode;
    assign out_stack_index   = head.stack_index;
    assign out_has_memory_op = head.has_memory_op;
    assign out_has_pop       = head.has_pop;
    assign out_has_push      = head.has_push;
    assign out_operand_size  = head.operand_size;
    assign out_is_integer    = head.is_integer;
    assign out_is_bcd        = head.is_bcd;
    assign out_uses_st0_sti  = head.uses_st0_sti;
    assign out_uses_sti_st0  = head.uses_sti_st0;
    assign out_illegal       = head.illegal;

`ifdef FPU_DECODE_QUEUE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_accepted <= '0;
            stat_illegal  <= '0;
        end else if (push) begin
            if (stat_accepted != 16'hFFFF) stat_accepted <= stat_accepted + 16'd1;
            if (!dec_valid && stat_illegal != 16'hFFFF) stat_illegal <= stat_illegal + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_decode_queue.sv
// Directed self-checking bench for fpu_decode_queue (DEPTH=4, TAG_W=4).
module tb_fpu_decode_queue;

    // {opcode, stack_index, mem, pop, push, size, int, bcd, st0_sti, sti_st0, illegal}
    localparam logic [20:0] E_D9E8 = {8'h9A, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [20:0] E_D9EB = {8'h9A, 3'd3, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [20:0] E_D9EE = {8'h9A, 3'd6, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [20:0] E_DB38 = {8'h3E, 3'd0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [20:0] E_D8C1 = {8'h80, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [20:0] E_DEC1 = {8'hE0, 3'd1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [20:0] E_DF20 = {8'h78, 3'd0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [20:0] E_ILL  = {8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_instr = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, out_valid;
    logic [7:0]  out_opcode;
    logic [2:0]  out_stack_index;
    logic        out_has_memory_op, out_has_pop, out_has_push;
    logic [1:0]  out_operand_size;
    logic        out_is_integer, out_is_bcd, out_uses_st0_sti, out_uses_sti_st0, out_illegal;
    logic [3:0]  out_tag;
    logic [2:0]  count;
`ifdef FPU_DECODE_QUEUE_STATS_EN
    logic [15:0] stat_accepted, stat_illegal;
`endif

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [20:0] head_bits;
    logic [3:0]  q_tag[$];
    logic [20:0] q_bits[$];

    always #5 clk = ~clk;

    fpu_decode_queue #(.DEPTH(4), .TAG_W(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_instr          (in_instr),
        .in_tag            (in_tag),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_opcode        (out_opcode),
        .out_stack_index   (out_stack_index),
        .out_has_memory_op (out_has_memory_op),
        .out_has_pop       (out_has_pop),
        .out_has_push      (out_has_push),
        .out_operand_size  (out_operand_size),
        .out_is_integer    (out_is_integer),
        .out_is_bcd        (out_is_bcd),
        .out_uses_st0_sti  (out_uses_st0_sti),
        .out_uses_sti_st0  (out_uses_sti_st0),
        .out_illegal       (out_illegal),
        .out_tag           (out_tag),
        .count             (count)
`ifdef FPU_DECODE_QUEUE_STATS_EN
        ,
        .stat_accepted     (stat_accepted),
        .stat_illegal      (stat_illegal)
`endif
    );

    assign head_bits = {out_opcode, out_stack_index, out_has_memory_op, out_has_pop, out_has_push,
                        out_operand_size, out_is_integer, out_is_bcd, out_uses_st0_sti,
                        out_uses_sti_st0, out_illegal};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] instr, input logic [3:0] tag);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        tests_run++; if (head_bits !== 21'h0 || out_tag !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %h/%h want 0/0", head_bits, out_tag); end
        tick();
        tick();
        reset = 1'b0;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_push();
        in_valid = 1'b1;
        in_instr = 16'hD9E8;
        in_tag   = 4'd1;
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL no_comb_path: got %b want 0", out_valid); end
        tick();
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_out_valid: got %b want 1", out_valid); end
        tests_run++; if (head_bits !== E_D9E8) begin tests_failed++; $display("[TB] FAIL single_bundle: got %h want %h", head_bits, E_D9E8); end
        tests_run++; if (out_tag !== 4'd1) begin tests_failed++; $display("[TB] FAIL single_tag: got %0d want 1", out_tag); end
        tests_run++; if (count !== 3'd1) begin tests_failed++; $display("[TB] FAIL single_count: got %0d want 1", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || count !== 3'd0) begin tests_failed++; $display("[TB] FAIL single_pop: got valid %b count %0d want 0 0", out_valid, count); end
    endtask

    task automatic test_fill_drain();
        logic [15:0] instrs [4];
        logic [20:0] exps [4];
        instrs = '{16'hD9E8, 16'hD9EB, 16'hD9EE, 16'hDB38};
        exps   = '{E_D9E8, E_D9EB, E_D9EE, E_DB38};
        for (int i = 0; i < 4; i++) push_one(instrs[i], 4'(i));
        tests_run++; if (count !== 3'd4) begin tests_failed++; $display("[TB] FAIL fill_count: got %0d want 4", count); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_in_ready: got %b want 0", in_ready); end
        push_one(16'hD8C1, 4'hF);
        tests_run++; if (count !== 3'd4) begin tests_failed++; $display("[TB] FAIL full_no_capture: got %0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (out_valid !== 1'b1 || head_bits !== exps[i] || out_tag !== 4'(i)) begin
                tests_failed++; $display("[TB] FAIL drain_%0d: got %b %h tag %0d want 1 %h tag %0d", i, out_valid, head_bits, out_tag, exps[i], i);
            end
            tick();
        end
        out_ready = 1'b0;
        tests_run++; if (count !== 3'd0 || out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_empty: got count %0d valid %b want 0 0", count, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] instrs [5];
        logic [20:0] exps [5];
        instrs = '{16'hDB38, 16'hD8C1, 16'hDEC1, 16'hDF20, 16'hD9E8};
        exps   = '{E_DB38, E_D8C1, E_DEC1, E_DF20, E_D9E8};
        q_tag.delete();
        q_bits.delete();
        for (int i = 1; i < 5; i++) begin
            push_one(instrs[i], 4'(i - 1));
            q_tag.push_back(4'(i - 1));
            q_bits.push_back(exps[i]);
        end
        in_valid  = 1'b1;
        in_instr  = instrs[0];
        in_tag    = 4'd4;
        out_ready = 1'b1;
        tick();
        void'(q_tag.pop_front());
        void'(q_bits.pop_front());
        tests_run++; if (count !== 3'd3) begin tests_failed++; $display("[TB] FAIL full_pushpop_count: got %0d want 3", count); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_pushpop_ready: got %b want 1", in_ready); end
        tests_run++; if (out_tag !== 4'd1) begin tests_failed++; $display("[TB] FAIL full_pushpop_head: got %0d want 1", out_tag); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_instr = instrs[i % 5];
            in_tag   = 4'(4 + i);
            tests_run++; if (out_valid !== 1'b1 || out_tag !== q_tag[0] || head_bits !== q_bits[0]) begin
                tests_failed++; $display("[TB] FAIL wrap_%0d: got %b tag %0d %h want 1 tag %0d %h", i, out_valid, out_tag, head_bits, q_tag[0], q_bits[0]);
            end
            tick();
            void'(q_tag.pop_front());
            void'(q_bits.pop_front());
            q_tag.push_back(4'(4 + i));
            q_bits.push_back(exps[i % 5]);
        end
        in_valid = 1'b0;
        tests_run++; if (count !== 3'd3) begin tests_failed++; $display("[TB] FAIL wrap_count: got %0d want 3", count); end
        while (q_tag.size() > 0) begin
            tests_run++; if (out_valid !== 1'b1 || out_tag !== q_tag[0] || head_bits !== q_bits[0]) begin
                tests_failed++; $display("[TB] FAIL wrap_drain: got %b tag %0d %h want 1 tag %0d %h", out_valid, out_tag, head_bits, q_tag[0], q_bits[0]);
            end
            tick();
            void'(q_tag.pop_front());
            void'(q_bits.pop_front());
        end
        out_ready = 1'b0;
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL wrap_empty: got %0d want 0", count); end
    endtask

    task automatic test_illegal();
        reset = 1'b1;
        #2 reset = 1'b0;
        push_one(16'h1234, 4'd5);
        tests_run++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin tests_failed++; $display("[TB] FAIL illegal_flag: got valid %b illegal %b want 1 1", out_valid, out_illegal); end
        tests_run++; if (head_bits !== E_ILL || out_tag !== 4'd5) begin tests_failed++; $display("[TB] FAIL illegal_bundle: got %h tag %0d want %h tag 5", head_bits, out_tag, E_ILL); end
`ifdef FPU_DECODE_QUEUE_STATS_EN
        tests_run++; if (stat_accepted !== 16'd1 || stat_illegal !== 16'd1) begin tests_failed++; $display("[TB] FAIL stats_first: got %0d/%0d want 1/1", stat_accepted, stat_illegal); end
`endif
        push_one(16'hD8C1, 4'd6);
`ifdef FPU_DECODE_QUEUE_STATS_EN
        tests_run++; if (stat_accepted !== 16'd2 || stat_illegal !== 16'd1) begin tests_failed++; $display("[TB] FAIL stats_legal: got %0d/%0d want 2/1", stat_accepted, stat_illegal); end
`endif
        out_ready = 1'b1;
        tick();
        tests_run++; if (head_bits !== E_D8C1 || out_tag !== 4'd6) begin tests_failed++; $display("[TB] FAIL after_illegal: got %h tag %0d want %h tag 6", head_bits, out_tag, E_D8C1); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        push_one(16'hD9E8, 4'd7);
        push_one(16'hD9EB, 4'd8);
        push_one(16'hD9EE, 4'd9);
        tests_run++; if (count !== 3'd3) begin tests_failed++; $display("[TB] FAIL flush_pre_count: got %0d want 3", count); end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 16'hD8C1;
        in_tag   = 4'hA;
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests_run++; if (count !== 3'd0 || out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_clear: got count %0d valid %b want 0 0", count, out_valid); end
        tick();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_no_capture: got %b want 0", out_valid); end
        push_one(16'hDEC1, 4'hB);
        tests_run++; if (head_bits !== E_DEC1 || out_tag !== 4'hB) begin tests_failed++; $display("[TB] FAIL post_flush_head: got %h tag %0d want %h tag 11", head_bits, out_tag, E_DEC1); end
`ifdef FPU_DECODE_QUEUE_STATS_EN
        tests_run++; if (stat_accepted !== 16'd6 || stat_illegal !== 16'd1) begin tests_failed++; $display("[TB] FAIL stats_flush: got %0d/%0d want 6/1", stat_accepted, stat_illegal); end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        push_one(16'hD9E8, 4'd1);
        push_one(16'hDB38, 4'd2);
        tests_run++; if (count !== 3'd2) begin tests_failed++; $display("[TB] FAIL areset_pre_count: got %0d want 2", count); end
        #3 reset = 1'b1;
        #1;
        tests_run++; if (count !== 3'd0 || out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL areset_immediate: got count %0d valid %b want 0 0", count, out_valid); end
        tests_run++; if (head_bits !== 21'h0) begin tests_failed++; $display("[TB] FAIL areset_data: got %h want 0", head_bits); end
        #1 reset = 1'b0;
        tick();
        tests_run++; if (in_ready !== 1'b1 || count !== 3'd0) begin tests_failed++; $display("[TB] FAIL areset_release: got ready %b count %0d want 1 0", in_ready, count); end
`ifdef FPU_DECODE_QUEUE_STATS_EN
        tests_run++; if (stat_accepted !== 16'd0) begin tests_failed++; $display("[TB] FAIL areset_stats: got %0d want 0", stat_accepted); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_drain();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
